// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and defaults for the FIFO write-port arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_IDX_W  = $clog2(DEF_N_REQ);
    localparam int DEF_DATA_W = 8;

    // Index width that stays at least one bit wide for any legal requester count.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rtl/fifo_wr_arbiter_rr_picker.sv - rotating-priority first-one finder
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    int               scan;
    logic [IDX_W-1:0] cand;

    // Walk rr_ptr, rr_ptr+1, ... with wrap by compare so N_REQ need not be a power of two.
    always_comb begin
        found = 1'b0;
        index = '0;
        scan  = 0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = int'(rr_ptr) + k;
            if (scan >= N_REQ) begin
                scan = scan - N_REQ;
            end
            cand = IDX_W'(scan);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = DEF_N_REQ,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int MAX_BURST = 4,
    parameter  int CNT_W     = 16,
    localparam int IDX_W     = idx_w(N_REQ)
) (
    input  logic                    wr_clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    full,
    output logic                    wr_en,
    output logic [DATA_W-1:0]       wr_data,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    busy,
    output logic [CNT_W-1:0]        wr_count
);

    localparam int               CB_W       = $clog2(MAX_BURST + 1);
    localparam logic [CB_W-1:0]  BURST_LAST = CB_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_REQ - 1);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] owner, owner_n;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_n;
    logic [CB_W-1:0]  burst_cnt, burst_cnt_n;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_LAST) ? '0 : i + 1'b1;
    endfunction

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .found     (pick_found),
        .index     (pick_idx)
    );

    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        burst_cnt_n = burst_cnt;
        req_ready   = '0;
        sel         = owner;
        grant_id    = '0;
        if (!rst) begin
            if (state == IDLE) begin
                if (pick_found && !full) begin
                    sel                 = pick_idx;
                    grant_id            = pick_idx;
                    req_ready[pick_idx] = 1'b1;
                    if (MAX_BURST == 1) begin
                        rr_ptr_n = next_idx(pick_idx);
                    end else begin
                        state_n     = BURST;
                        owner_n     = pick_idx;
                        burst_cnt_n = CB_W'(1);
                    end
                end
            end else begin
                grant_id = owner;
                if (!full) begin
                    if (req_valid[owner]) begin
                        req_ready[owner] = 1'b1;
                        if (burst_cnt + 1'b1 == BURST_LAST) begin
                            state_n     = IDLE;
                            rr_ptr_n    = next_idx(owner);
                            burst_cnt_n = '0;
                        end else begin
                            burst_cnt_n = burst_cnt + 1'b1;
                        end
                    end else begin
                        // Owner went quiet: give up the lock, costing one bubble cycle.
                        state_n     = IDLE;
                        rr_ptr_n    = next_idx(owner);
                        burst_cnt_n = '0;
                    end
                end
            end
        end
    end

    assign wr_en   = |req_ready;
    assign wr_data = req_data[sel*DATA_W +: DATA_W];
    assign busy    = (state == BURST);

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            wr_count  <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            burst_cnt <= burst_cnt_n;
            if (wr_en) begin
                wr_count <= wr_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for the FIFO write-port arbiter
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int CW = 16;

    logic            wr_clk = 1'b0;
    logic            rst = 1'b1;
    logic            full = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [1:0]      grant_id;
    logic            busy;
    logic [CW-1:0]   wr_count;

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .CNT_W(CW)) dut (
        .wr_clk    (wr_clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .full      (full),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy),
        .wr_count  (wr_count)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          busy;
        logic [CW-1:0] count;
        logic [N-1:0]  ready;
    } st_t;

    wr_t           exp_wr[$];
    st_t           exp_st[$];
    int            glog[$];
    logic [DW-1:0] feed_q[N][$];
    logic          pend_v[N];
    logic [DW-1:0] pend_d[N];
    int            n_checks = 0;
    int            n_pass = 0;
    bit            rand_on = 0;

    // Reference model: lock owner (-1 = none), words sent in this lock, priority start, write total.
    int            m_owner = -1;
    int            m_cnt = 0;
    int            m_ptr = 0;
    int unsigned   m_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) begin
            if (pend_v[i] || feed_q[i].size() > 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One wr_clk cycle: present producer words, predict the outcome, then cross the edge.
    task automatic cycle(input bit r, input bit f);
        int  w;
        st_t s;
        for (int i = 0; i < N; i++) begin
            if (!pend_v[i] && feed_q[i].size() > 0) begin
                pend_v[i] = 1'b1;
                pend_d[i] = feed_q[i].pop_front();
            end else if (!pend_v[i] && rand_on && $urandom_range(99) < 40) begin
                pend_v[i] = 1'b1;
                pend_d[i] = DW'($urandom);
            end
            req_valid[i]          = pend_v[i];
            req_data[i*DW +: DW]  = pend_d[i];
        end
        rst     = r;
        full    = f;
        s.busy  = (m_owner >= 0);
        s.count = CW'(m_count);
        s.ready = '0;
        w       = -1;
        if (r) begin
            m_owner = -1;
            m_cnt   = 0;
            m_ptr   = 0;
            m_count = 0;
        end else if (!f) begin
            if (m_owner >= 0 && !pend_v[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
            end else begin
                if (m_owner < 0) begin
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && pend_v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                    end
                    if (w >= 0) begin
                        m_owner = w;
                        m_cnt   = 0;
                    end
                end else begin
                    w = m_owner;
                end
                if (w >= 0) begin
                    m_cnt++;
                    m_count++;
                    s.ready[w] = 1'b1;
                    exp_wr.push_back('{w, pend_d[w]});
                    pend_v[w] = 1'b0;
                    if (m_cnt == MB) begin
                        m_ptr   = (w + 1) % N;
                        m_owner = -1;
                        m_cnt   = 0;
                    end
                end
            end
        end
        exp_st.push_back(s);
        @(posedge wr_clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((any_pending() || m_owner >= 0) && n < 300) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            $display("FAIL drain_timeout: still pending after %0d cycles, required to empty", n);
        end
    endtask

    initial begin : monitor
        st_t s;
        wr_t w;
        forever begin
            @(negedge wr_clk);
            if (exp_st.size() > 0) begin
                s = exp_st.pop_front();
                check("busy", busy, s.busy);
                check("wr_count", wr_count, s.count);
                check("req_ready", req_ready, s.ready);
                check("wr_en", wr_en, |s.ready);
                check("wr_en_while_full", wr_en & full, 0);
                if (wr_en) begin
                    glog.push_back(int'(grant_id));
                    if (exp_wr.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_write: got data %0h, required no write", wr_data);
                    end else begin
                        w = exp_wr.pop_front();
                        check("wr_data", wr_data, w.data);
                        check("grant_id", grant_id, w.id);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [CW-1:0] c0;
        for (int i = 0; i < N; i++) begin
            pend_v[i] = 1'b0;
            pend_d[i] = '0;
        end
        @(posedge wr_clk);
        #1;

        // Reset with every requester waiting, then first grant goes to req0.
        for (int i = 0; i < N; i++) feed_q[i].push_back(DW'(8'hA0 + i));
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("reset_wr_count", wr_count, 0);
        glog.delete();
        drain();
        check("first_grant", (glog.size() > 0) ? glog[0] : 99, 0);

        // Single requester streaming six words across a burst boundary.
        glog.delete();
        for (int k = 1; k <= 6; k++) feed_q[1].push_back(DW'(k));
        c0 = wr_count;
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0);
        check("single_count", CW'(wr_count - c0), 6);
        check("single_writes", glog.size(), 6);
        drain();

        // Fairness: all four valid continuously from a fresh reset.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 4; k++) feed_q[i].push_back(DW'(8'h30 + 16 * i + k));
        cycle(1'b1, 1'b0);
        glog.delete();
        for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0);
        check("fair_writes", glog.size(), 16);
        for (int k = 0; k < 16 && k < glog.size(); k++) check($sformatf("fair_grant_%0d", k), glog[k], k / 4);

        // Back-pressure in the middle of req2's burst.
        glog.delete();
        for (int k = 0; k < 4; k++) feed_q[2].push_back(DW'(8'h50 + k));
        for (int k = 0; k < 2; k++) feed_q[3].push_back(DW'(8'h60 + k));
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        c0 = wr_count;
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
        check("bp_no_writes", CW'(wr_count - c0), 0);
        check("bp_locked", busy, 1);
        drain();
        check("bp_total", glog.size(), 6);
        check("bp_next_owner", (glog.size() == 6) ? glog[4] : 99, 3);

        // Early release by req1 hands over to req3 after one bubble.
        glog.delete();
        for (int k = 0; k < 2; k++) feed_q[1].push_back(DW'(8'h71 + k));
        for (int k = 0; k < 3; k++) feed_q[3].push_back(DW'(8'h81 + k));
        c0 = wr_count;
        drain();
        check("early_count", CW'(wr_count - c0), 5);
        check("early_next", (glog.size() == 5) ? glog[2] : 99, 3);

        // Reset landing on req0's third burst word.
        for (int k = 0; k < 5; k++) feed_q[0].push_back(DW'(8'h91 + k));
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("midrst_count", wr_count, 0);
        check("midrst_busy", busy, 0);
        drain();

        // Randomized traffic with back-pressure and occasional reset.
        rand_on = 1;
        for (int k = 0; k < 400; k++) cycle($urandom_range(99) < 2, $urandom_range(99) < 25);
        rand_on = 0;
        drain();
        cycle(1'b0, 1'b0);
        check("scoreboard_empty", exp_wr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the single write port of async_fifo among N_REQ producers in the wr_clk domain.
- Each producer uses a valid/ready handshake.
- A granted producer may send a burst of up to MAX_BURST consecutive words before priority rotates.
- The block honours the FIFO full flag and never asserts wr_en while full is high.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, word width; matches the FIFO data width.
- MAX_BURST, 4, maximum consecutive words per grant (>=1).
- CNT_W, 16, width of the accepted-word counter.

Ports:
- wr_clk  in  1  clock; the FIFO write clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester word valid.
- req_data  in  N_REQ*DATA_W  requester i's word at bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i].
- full  in  1  FIFO full flag (wr_clk domain).
- wr_en  out  1  FIFO write enable.
- wr_data  out  DATA_W  FIFO write data.
- grant_id  out  clog2(N_REQ)  index of the selected requester; 0 when none.
- busy  out  1  high while a burst owner is locked.
- wr_count  out  CNT_W  total accepted words; wraps modulo 2^CNT_W.

Behaviour:
- Registered state:
  - state: IDLE or BURST.
  - owner.
  - rr_ptr: the highest-priority index.
  - burst_cnt: 0..MAX_BURST.
  - wr_count.
- On reset: state=IDLE, owner=0, rr_ptr=0, burst_cnt=0, wr_count=0.
- While rst is high, wr_en=0 and req_ready=0, combinationally gated.
- req_ready, wr_en, wr_data and grant_id are combinational from the registered state plus req_valid/full.
  - There is zero latency: the word is written into the FIFO on the same wr_clk edge as the handshake.
  - wr_en = |req_ready; wr_data = req_data of the granted index.
- Requester rule: once valid is asserted, valid and data are held stable until accepted.
- IDLE:
  - The winner is the first i with req_valid[i] set, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - If a winner exists and full=0, the transfer happens this cycle.
  - If MAX_BURST=1: stay in IDLE, rr_ptr=winner+1.
  - Otherwise: go to BURST with owner=winner and burst_cnt=1.
  - If full=1: no grant, no lock, remain in IDLE; arbitration re-evaluates next cycle.
- BURST:
  - Only the owner can receive ready: req_ready[owner] = req_valid[owner] & ~full.
  - On a transfer, burst_cnt increments. If it reaches MAX_BURST: go to IDLE, rr_ptr=owner+1, burst_cnt=0.
  - If full=1: stall and hold all state.
  - If full=0 and req_valid[owner]=0: release to IDLE with rr_ptr=owner+1. This is a one-cycle bubble; no write occurs that cycle.
- wr_count increments by 1 on every cycle with wr_en=1.
- rr_ptr wraps from N_REQ-1 to 0. No power-of-two N_REQ is required; wrap is done by compare.
- Reset asserted mid-burst: the next edge returns to reset values. Requesters holding valid are re-arbitrated from index 0.
- No write is ever issued with full=1. A grant never goes to a requester whose req_valid is low.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - a localparam for the clog2(N_REQ) index width;
  - the default DATA_W of 8.
- Sub-module rr_picker: combinational rotating-priority first-one finder.
  - Inputs: req_valid, rr_ptr.
  - Outputs: found, index.
  - Instantiated once, for IDLE arbitration.

Test Plan:
1. Reset: hold rst 2 cycles with req_valid=4'b1111 -> wr_en=0, req_ready=0, wr_count=0, busy=0. After release, req0 is granted first.
2. Single requester: req1 only, 6 words 0x01..0x06, MAX_BURST=4 -> 6 writes in 6 consecutive cycles, in order, grant_id=1, wr_count=6. busy drops for exactly one cycle after the 4th word, with no bubble.
3. Fairness: all four valid continuously -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,... with 16 writes in 16 cycles.
4. Back-pressure: full=1 for 3 cycles after req2's 2nd burst word -> wr_en=0 and req_ready=0 for those 3 cycles. Owner stays 2. req2 then writes 2 more words, then req3 is granted. No data lost or duplicated.
5. Early release: req1 owner drops valid after 2 words while req3 is valid -> one idle cycle, then req3 is granted (rr_ptr=2, scan hits 3). wr_count increases by the exact accepted total.
6. Mid-burst reset: assert rst during req0's 3rd word -> no write in the rst cycle. Next state is IDLE, wr_count=0, rr_ptr=0.
